mem_bus_slave: RTL
==================

MEM_BUS_SLAVE -- requirements
Module: mem_bus_slave

Interface
REQ-001 Parameter ADDR_W, default 8: log2 of word depth; memory is 2^ADDR_W x 64-bit words.
REQ-002 Parameter WAIT_CYCLES, default 2: access wait states, range 0..15.
REQ-003 Clock  input  1  single clock for all state; all sampling on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Data_in  input  64  value on the shared multiplexed bus; carries the address during the ALE phase and write data otherwise.
REQ-006 Data_out  output  64  read data for the shared bus.
REQ-007 ENB  output  1  active-low bus drive enable; the pad tristates Data when ENB=1.
REQ-008 nME  input  1  active-low memory enable; frames one bus transaction.
REQ-009 nALE  input  1  active-low address latch enable.
REQ-010 RnW  input  1  1=read, 0=write; sampled when the address phase ends.
REQ-011 nOE  input  1  active-low output enable from the bus master.
REQ-012 Busy  output  1  high while an access is in progress, from ADDR through WDONE/RDRIVE.

Function
REQ-013 The block SHALL implement the FSM states IDLE, ADDR, WAIT, RDRIVE, WDONE.
REQ-014 IDLE: if nME=0 and nALE=0, SHALL latch addr=Data_in[ADDR_W+2:3] and go to ADDR; otherwise stay in IDLE.
REQ-015 Data_in[2:0] and Data_in bits above ADDR_W+2 SHALL be ignored, so addresses wrap modulo 2^ADDR_W words.
REQ-016 ADDR: while nALE=0, SHALL re-latch addr each cycle; on the first cycle with nALE=1, SHALL capture RnW into dir, load cnt=WAIT_CYCLES and go to WAIT.
REQ-017 WAIT: if cnt!=0, SHALL decrement cnt.
REQ-018 WAIT with cnt=0 and dir=read: SHALL load Data_out=mem[addr] and go to RDRIVE.
REQ-019 WAIT with cnt=0 and dir=write: SHALL write mem[addr]=Data_in and go to WDONE.
REQ-020 With WAIT_CYCLES=0, the read or write SHALL occur on the first WAIT cycle.
REQ-021 RDRIVE and WDONE SHALL hold until nME=1.
REQ-022 ENB SHALL be combinational: ENB=0 iff state=RDRIVE and nOE=0 and nME=0; ENB=1 in all other cases.
REQ-023 Read latency SHALL be WAIT_CYCLES+2 rising edges, counted from the edge that sees nALE=1 in ADDR to the first edge where Data_out is valid.
REQ-024 Data_out SHALL hold its value until the next read load.
REQ-025 nME=1 sampled in any state except IDLE SHALL force IDLE on that edge; a write not yet committed in WAIT SHALL be aborted and leave memory unchanged.
REQ-026 nME=1 in the same cycle as the WAIT commit condition: abort SHALL take priority, with no memory write and no Data_out load.
REQ-027 nALE=0 while in WAIT, RDRIVE or WDONE SHALL be ignored; a new address is accepted only from IDLE.
REQ-028 Changes of RnW after the ADDR exit SHALL be ignored for the rest of the transaction.
REQ-029 Back-to-back transactions SHALL require nME=1 for at least one cycle between accesses.

Reset
REQ-030 Reset=1 SHALL immediately force state=IDLE, ENB=1, Busy=0, Data_out=0, addr=0, cnt=0, dir=read, independent of Clock.
REQ-031 Memory contents SHALL NOT be reset.
REQ-032 Reset asserted mid-access SHALL abort any uncommitted write, and ENB SHALL go to 1 without waiting for a clock edge.
REQ-033 After Reset is released, the block SHALL accept a new transaction on the first rising edge.

Verification
REQ-034 Write then read, WAIT_CYCLES=2: write 0xDEADBEEF_01234567 to byte address 0x40, then read 0x40 -> Data_out=0xDEADBEEF_01234567 with ENB=0 on the 4th edge after nALE=1, while nOE=0.
REQ-035 Wrap test, ADDR_W=8: write 0x1 to byte address 0x800 and read byte address 0x000 -> Data_out=0x1; low bits 0x7 in the address are ignored.
REQ-036 Write abort: nME=1 during WAIT with cnt=1 -> state returns to IDLE and a subsequent read of that address returns its prior value.
REQ-037 nOE gating: in RDRIVE toggle nOE 0/1/0 -> ENB follows 0/1/0 combinationally; with nME=1, ENB=1.
REQ-038 Async reset: assert Reset between clock edges during RDRIVE -> ENB=1, Busy=0 and Data_out=0 immediately; memory is preserved for a post-reset read.
REQ-039 WAIT_CYCLES=0: a read returns data 2 edges after nALE=1, and a back-to-back read with a one-cycle nME=1 gap succeeds.

Source files
------------

// File: rtl/mem_bus_slave.sv
// Word-addressed 64-bit memory slave on a multiplexed address/data bus.
// Programmable wait states, drive enable for an external tristate pad.
module mem_bus_slave #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [63:0] Data_in,
    output logic [63:0] Data_out,
    output logic        ENB,
    input  logic        nME,
    input  logic        nALE,
    input  logic        RnW,
    input  logic        nOE,
    output logic        Busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_WAIT,
        S_RDRIVE,
        S_WDONE
    } state_t;

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_cnt;
    logic              r_dir;
    logic [63:0]       r_dout;
    logic [63:0]       r_mem [2**ADDR_W];

    logic w_commit;
    logic w_rd_load;
    logic w_wr_en;

    // nME high always wins over the commit, so an abort never touches memory
    assign w_commit  = (r_state == S_WAIT) && (r_cnt == 4'd0) && !nME;
    assign w_rd_load = w_commit && r_dir;
    assign w_wr_en   = w_commit && !r_dir;

    assign Data_out = r_dout;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (!nME && !nALE) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                if (nME) begin
                    w_next = S_IDLE;
                end else if (nALE) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (nME) begin
                    w_next = S_IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next = r_dir ? S_RDRIVE : S_WDONE;
                end
            end
            S_RDRIVE, S_WDONE: begin
                if (nME) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        ENB  = 1'b1;
        Busy = 1'b0;
        if (r_state != S_IDLE) begin
            Busy = 1'b1;
        end
        if ((r_state == S_RDRIVE) && !nOE && !nME) begin
            ENB = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_dir  <= 1'b1;
            r_dout <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!nME && !nALE) begin
                        r_addr <= Data_in[ADDR_W+2:3];
                    end
                end
                S_ADDR: begin
                    if (!nME) begin
                        if (!nALE) begin
                            r_addr <= Data_in[ADDR_W+2:3];
                        end else begin
                            r_dir <= RnW;
                            r_cnt <= LP_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (!nME && (r_cnt != 4'd0)) begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                    if (w_rd_load) begin
                        r_dout <= r_mem[r_addr];
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain
    always_ff @(posedge Clock) begin
        if (w_wr_en) begin
            r_mem[r_addr] <= Data_in;
        end
    end

endmodule
